// File: rtl/bldc_hall_emulator.sv
// Virtual BLDC motor: emits a 6-step hall pattern at a programmable period and direction,
// with a signed net step count. Optional macro HALL_FAULT_INJECT_EN adds i_hall_fault (forces hall=111).
module bldc_hall_emulator #(
  parameter int PERIOD_WIDTH  = 16,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
`ifdef HALL_FAULT_INJECT_EN
  input  logic                     i_hall_fault,
`endif
  input  logic                     i_enable,
  input  logic                     i_dir,
  input  logic [PERIOD_WIDTH-1:0]  i_period,
  input  logic                     i_period_load,
  output logic [2:0]               o_hall,
  output logic                     o_step_strobe,
  output logic [COUNTER_WIDTH-1:0] o_step_count
);

  // state  | meaning
  // S_IDX0 | hall 101
  // S_IDX1 | hall 100
  // S_IDX2 | hall 110
  // S_IDX3 | hall 010
  // S_IDX4 | hall 011
  // S_IDX5 | hall 001
  typedef enum logic [2:0] {
    S_IDX0 = 3'd0,
    S_IDX1 = 3'd1,
    S_IDX2 = 3'd2,
    S_IDX3 = 3'd3,
    S_IDX4 = 3'd4,
    S_IDX5 = 3'd5
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0]  PER_ONE = PERIOD_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [PERIOD_WIDTH-1:0]    r_period_active;
  logic [PERIOD_WIDTH-1:0]    r_timer;
  logic [COUNTER_WIDTH-1:0]   r_step_count;
  logic                       r_strobe;
  logic [2:0]                 r_hall;
  logic                       w_run;
  logic                       w_step;
  logic                       w_fault;
  logic [2:0]                 w_hall_next;

`ifdef HALL_FAULT_INJECT_EN
  assign w_fault = i_hall_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign w_run  = i_enable && (r_period_active != '0);
  // A coincident period load suppresses the step.
  assign w_step = w_run && !i_period_load && (r_timer == (r_period_active - PER_ONE));

  always_comb begin
    w_state_next = r_state;
    if (w_step) begin
      if (i_dir) begin
        case (r_state)
          S_IDX0:  w_state_next = S_IDX1;
          S_IDX1:  w_state_next = S_IDX2;
          S_IDX2:  w_state_next = S_IDX3;
          S_IDX3:  w_state_next = S_IDX4;
          S_IDX4:  w_state_next = S_IDX5;
          default: w_state_next = S_IDX0;
        endcase
      end else begin
        case (r_state)
          S_IDX0:  w_state_next = S_IDX5;
          S_IDX1:  w_state_next = S_IDX0;
          S_IDX2:  w_state_next = S_IDX1;
          S_IDX3:  w_state_next = S_IDX2;
          S_IDX4:  w_state_next = S_IDX3;
          default: w_state_next = S_IDX4;
        endcase
      end
    end
  end

  always_comb begin
    w_hall_next = 3'b101;
    case (w_state_next)
      S_IDX0:  w_hall_next = 3'b101;
      S_IDX1:  w_hall_next = 3'b100;
      S_IDX2:  w_hall_next = 3'b110;
      S_IDX3:  w_hall_next = 3'b010;
      S_IDX4:  w_hall_next = 3'b011;
      default: w_hall_next = 3'b001;
    endcase
    if (w_fault) w_hall_next = 3'b111;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDX0;
      r_period_active <= '0;
      r_timer         <= '0;
      r_step_count    <= '0;
      r_strobe        <= 1'b0;
      r_hall          <= 3'b101;
    end else begin
      r_state  <= w_state_next;
      r_hall   <= w_hall_next;
      r_strobe <= w_step;
      if (i_period_load) begin
        r_period_active <= i_period;
        r_timer         <= '0;
      end else if (w_step) begin
        r_timer <= '0;
      end else if (w_run) begin
        r_timer <= r_timer + PER_ONE;
      end
      if (w_step) begin
        r_step_count <= i_dir ? (r_step_count + CNT_ONE) : (r_step_count - CNT_ONE);
      end
    end
  end

  assign o_hall        = r_hall;
  assign o_step_strobe = r_strobe;
  assign o_step_count  = r_step_count;

endmodule
